effect_chain_sequencer: RTL and testbench
=========================================

EFFECT_CHAIN_SEQUENCER -- requirements
Module: effect_chain_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: number of chained effect stages.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 12: signed sample width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles waited per stage.
REQ-004 SHALL have parameter RESET_CYCLES, default 2: stage_reset pulse length.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset, as already decided.
REQ-006 SHALL have these ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- sample_ready  in  1  one-cycle strobe; new input sample.
- incoming_sample  in  SAMPLE_WIDTH  signed input sample.
- delay_amount_in  in  6  requested delay setting.
- enable_mask_in  in  NUM_STAGES  requested per-stage enables.
- stage_sample_in  out  SAMPLE_WIDTH  shared sample bus to stages.
- stage_sample_out  in  NUM_STAGES*SAMPLE_WIDTH  flattened stage results; stage i at bits [i*W +: W].
- stage_start  out  NUM_STAGES  one-hot start pulse.
- stage_done  in  NUM_STAGES  per-stage done level.
- stage_reset  out  1  reset pulse to all stages.
- stage_enable  out  NUM_STAGES  applied enables.
- delay_amount  out  6  applied delay setting.
- modified_sample  out  SAMPLE_WIDTH  chain output.
- output_valid  out  1  one-cycle strobe; modified_sample is new.
- busy  out  1  high whenever state is not IDLE.
- timeout_flag  out  1  sticky; a stage timed out.
- overrun_count  out  8  saturating count of dropped samples.

Function
REQ-007 SHALL implement FSM states IDLE, CONFIG, SELECT, ISSUE, SETTLE, WAIT.
REQ-008 In IDLE with sample_ready: SHALL capture incoming_sample into the working sample, set idx=0, and go to SELECT.
REQ-009 In IDLE without sample_ready, when delay_amount_in/enable_mask_in differ from the applied values: SHALL latch the new values, drive stage_reset high for RESET_CYCLES cycles (CONFIG), then return to IDLE.
REQ-010 If sample_ready and a config change coincide in IDLE, the sample SHALL take priority; the config is applied on a later IDLE cycle.
REQ-011 Config changes arriving outside IDLE SHALL be deferred, never applied mid-chain.
REQ-012 sample_ready in any state other than IDLE SHALL drop the sample and increment overrun_count, saturating at 255.
REQ-013 SELECT, stage idx disabled: SHALL spend one cycle and advance idx without asserting start.
REQ-014 SELECT, stage idx enabled: SHALL drive the working sample on stage_sample_in and go to ISSUE.
REQ-015 ISSUE: SHALL assert stage_start[idx] for exactly one cycle, then go to SETTLE.
REQ-016 SETTLE: SHALL ignore stage_done for one cycle, covering the stage's registered done deassert, then go to WAIT.
REQ-017 WAIT: when stage_done[idx]=1, SHALL load stage_sample_out[idx] into the working sample, then advance idx.
REQ-018 WAIT: if TIMEOUT_CYCLES elapse without done, SHALL keep the working sample unchanged (bypass), set timeout_flag, and advance idx.
REQ-019 On advancing past the last stage: SHALL register modified_sample=working sample, pulse output_valid for one cycle, and go to IDLE.
REQ-020 With all stages disabled and sample_ready in cycle 0, output_valid SHALL be high in cycle NUM_STAGES+1.
REQ-021 Each enabled stage SHALL add 3 + (stage done latency) cycles to the chain.
REQ-022 No arithmetic SHALL be performed on samples; they pass through at full width with sign preserved.
REQ-023 stage_sample_in SHALL hold its value from SELECT until the stage completes.

Reset
REQ-024 While reset is high: state=IDLE, idx=0, stage_start=0, output_valid=0, modified_sample=0, stage_sample_in=0, timeout_flag=0, overrun_count=0, delay_amount=0, stage_enable=0, and stage_reset=1.
REQ-025 After reset deasserts, stage_reset SHALL stay high for RESET_CYCLES further cycles.
REQ-026 Reset asserted mid-chain SHALL abort the chain immediately; no output_valid pulse is produced for the aborted sample.

Structure
REQ-027 A shared package SHALL hold the state encoding, SAMPLE_WIDTH, TIMEOUT_CYCLES, RESET_CYCLES and NUM_STAGES defaults.
REQ-028 The per-stage timeout SHALL be one sub-module, watchdog_counter (clear, enable, expired), of width clog2(TIMEOUT_CYCLES+1).

Verification
REQ-029 All stages disabled, sample_ready with incoming_sample=12'h123 -> modified_sample=12'h123; output_valid in cycle 4; stage_start never asserted.
REQ-030 Stage 0 enabled; model returns done 2 cycles after start with output=input-5; input 100 -> modified_sample=95; single stage_start[0] pulse.
REQ-031 Stage 1 model never raises done -> timeout_flag=1 after 1024 WAIT cycles; output equals stage-0 result; FSM back in IDLE.
REQ-032 delay_amount_in 0->8 while busy -> no change until IDLE; then delay_amount=8 and stage_reset high exactly 2 cycles.
REQ-033 Three sample_ready strobes during a long chain -> overrun_count=3; 300 strobes -> saturates at 255.
REQ-034 Reset asserted in WAIT -> all outputs at reset values next cycle; no output_valid pulse; stage_reset high 2 cycles after release.

Source files
------------

// File: rtl/effect_chain_sequencer_pkg.sv
// Shared types and default parameters for the effect chain sequencer.
package effect_chain_sequencer_pkg;

  localparam int DEF_NUM_STAGES     = 3;
  localparam int DEF_SAMPLE_WIDTH   = 12;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_RESET_CYCLES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_SELECT,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT
  } state_e;

  // Index width that stays legal for a single-stage chain.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/effect_chain_sequencer_watchdog_counter.sv
// Per-stage wait watchdog: counts enabled cycles, saturates at LIMIT.
module watchdog_counter #(
  parameter int LIMIT = 1024,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] r_cnt;

  // Count while enabled; clear dominates; hold once the limit is reached.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                r_cnt <= '0;
    else if (clear)                           r_cnt <= '0;
    else if (enable && r_cnt != CW'(LIMIT))   r_cnt <= r_cnt + 1'b1;
  end

  assign expired = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/effect_chain_sequencer.sv
// Sequences one sample at a time through a chain of external effect stages.
// Disabled stages are skipped in one cycle; a stage that never answers is
// bypassed after the watchdog expires.
module effect_chain_sequencer
  import effect_chain_sequencer_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               sample_ready,
  input  logic signed [SAMPLE_WIDTH-1:0]     incoming_sample,
  input  logic [5:0]                         delay_amount_in,
  input  logic [NUM_STAGES-1:0]              enable_mask_in,
  output logic signed [SAMPLE_WIDTH-1:0]     stage_sample_in,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stage_sample_out,
  output logic [NUM_STAGES-1:0]              stage_start,
  input  logic [NUM_STAGES-1:0]              stage_done,
  output logic                               stage_reset,
  output logic [NUM_STAGES-1:0]              stage_enable,
  output logic [5:0]                         delay_amount,
  output logic signed [SAMPLE_WIDTH-1:0]     modified_sample,
  output logic                               output_valid,
  output logic                               busy,
  output logic                               timeout_flag,
  output logic [7:0]                         overrun_count
);

  localparam int IW  = idx_width(NUM_STAGES);
  localparam int RCW = $clog2(RESET_CYCLES + 1);

  state_e                         r_state, w_state_n;
  logic [IW-1:0]                  r_idx;
  logic signed [SAMPLE_WIDTH-1:0] r_work;
  logic signed [SAMPLE_WIDTH-1:0] r_stage_sample_in;
  logic signed [SAMPLE_WIDTH-1:0] r_modified;
  logic                           r_output_valid;
  logic                           r_timeout;
  logic [7:0]                     r_overrun;
  logic [5:0]                     r_delay;
  logic [NUM_STAGES-1:0]          r_enable;
  logic [RCW-1:0]                 r_rst_cnt;

  logic                           w_capture, w_cfg_load, w_drive;
  logic                           w_load_stage, w_advance, w_timeout;
  logic                           w_last, w_expired, w_cfg_diff;
  logic signed [SAMPLE_WIDTH-1:0] w_stage_out [NUM_STAGES];
  logic signed [SAMPLE_WIDTH-1:0] w_next_work;

  // Unflatten the stage result bus so the current stage can be indexed.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_unpack
    assign w_stage_out[g] = stage_sample_out[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  assign w_last      = (r_idx == IW'(NUM_STAGES - 1));
  assign w_cfg_diff  = (delay_amount_in != r_delay) || (enable_mask_in != r_enable);
  assign w_next_work = w_load_stage ? w_stage_out[r_idx] : r_work;

  // Watchdog runs only in WAIT and restarts for every stage.
  watchdog_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (r_state != ST_WAIT),
    .enable  (r_state == ST_WAIT),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_n    = r_state;
    w_capture    = 1'b0;
    w_cfg_load   = 1'b0;
    w_drive      = 1'b0;
    w_load_stage = 1'b0;
    w_advance    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A waiting sample wins over a pending config change.
        if (sample_ready) begin
          w_capture = 1'b1;
          w_state_n = ST_SELECT;
        end else if (w_cfg_diff) begin
          w_cfg_load = 1'b1;
          w_state_n  = ST_CONFIG;
        end
      end
      ST_CONFIG: if (r_rst_cnt <= RCW'(1)) w_state_n = ST_IDLE;
      ST_SELECT: begin
        if (r_enable[r_idx]) begin
          w_drive   = 1'b1;
          w_state_n = ST_ISSUE;
        end else begin
          w_advance = 1'b1;
        end
      end
      ST_ISSUE:  w_state_n = ST_SETTLE;
      // Stage done is stale for one cycle after start; skip it.
      ST_SETTLE: w_state_n = ST_WAIT;
      ST_WAIT: begin
        if (stage_done[r_idx]) begin
          w_load_stage = 1'b1;
          w_advance    = 1'b1;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_advance = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (w_advance) w_state_n = w_last ? ST_IDLE : ST_SELECT;
  end

  // Working sample, stage index, outputs, config and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx             <= '0;
      r_work            <= '0;
      r_stage_sample_in <= '0;
      r_modified        <= '0;
      r_output_valid    <= 1'b0;
      r_timeout         <= 1'b0;
      r_overrun         <= '0;
      r_delay           <= '0;
      r_enable          <= '0;
      r_rst_cnt         <= RCW'(RESET_CYCLES);
    end else begin
      r_output_valid <= 1'b0;
      if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - 1'b1;
      if (w_cfg_load) begin
        r_delay   <= delay_amount_in;
        r_enable  <= enable_mask_in;
        r_rst_cnt <= RCW'(RESET_CYCLES);
      end
      if (w_capture) begin
        r_work <= incoming_sample;
        r_idx  <= '0;
      end
      if (w_drive) r_stage_sample_in <= r_work;
      if (w_advance) begin
        r_work <= w_next_work;
        r_idx  <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_modified     <= w_next_work;
          r_output_valid <= 1'b1;
        end
      end
      if (w_timeout) r_timeout <= 1'b1;
      if (sample_ready && r_state != ST_IDLE && r_overrun != 8'hFF)
        r_overrun <= r_overrun + 8'd1;
    end
  end

  // One-hot start while issuing the current stage.
  always_comb begin
    stage_start = '0;
    if (r_state == ST_ISSUE) stage_start[r_idx] = 1'b1;
  end

  assign stage_sample_in = r_stage_sample_in;
  assign stage_reset     = (r_rst_cnt != '0);
  assign stage_enable    = r_enable;
  assign delay_amount    = r_delay;
  assign modified_sample = r_modified;
  assign output_valid    = r_output_valid;
  assign busy            = (r_state != ST_IDLE);
  assign timeout_flag    = r_timeout;
  assign overrun_count   = r_overrun;

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Directed bench for effect_chain_sequencer with behavioural stage models.
module tb_effect_chain_sequencer;

  localparam int NS = 3;
  localparam int W  = 12;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                sample_ready = 1'b0;
  logic signed [W-1:0] incoming_sample = '0;
  logic [5:0]          delay_amount_in = '0;
  logic [NS-1:0]       enable_mask_in = '0;
  logic signed [W-1:0] stage_sample_in;
  logic [NS*W-1:0]     stage_sample_out;
  logic [NS-1:0]       stage_start;
  logic [NS-1:0]       stage_done;
  logic                stage_reset;
  logic [NS-1:0]       stage_enable;
  logic [5:0]          delay_amount;
  logic signed [W-1:0] modified_sample;
  logic                output_valid;
  logic                busy;
  logic                timeout_flag;
  logic [7:0]          overrun_count;

  int checks = 0;
  int errors = 0;

  // Stage model knobs: lat = cycles from start to done (0 = never), dlt added.
  int                  lat [NS];
  logic signed [W-1:0] dlt [NS];
  int                  rem [NS];
  logic signed [W-1:0] res [NS];
  int                  starts [NS];
  int                  vcount = 0;

  always #5 clock = ~clock;

  effect_chain_sequencer dut (
    .clock(clock), .reset(reset), .sample_ready(sample_ready),
    .incoming_sample(incoming_sample), .delay_amount_in(delay_amount_in),
    .enable_mask_in(enable_mask_in), .stage_sample_in(stage_sample_in),
    .stage_sample_out(stage_sample_out), .stage_start(stage_start),
    .stage_done(stage_done), .stage_reset(stage_reset),
    .stage_enable(stage_enable), .delay_amount(delay_amount),
    .modified_sample(modified_sample), .output_valid(output_valid),
    .busy(busy), .timeout_flag(timeout_flag), .overrun_count(overrun_count)
  );

  always_comb begin
    stage_sample_out = '0;
    for (int i = 0; i < NS; i++) stage_sample_out[i*W +: W] = res[i];
  end

  always @(posedge clock) begin
    for (int i = 0; i < NS; i++) begin
      if (stage_reset) begin
        stage_done[i] <= 1'b0;
        rem[i]        <= 0;
      end else if (stage_start[i]) begin
        res[i]        <= stage_sample_in + dlt[i];
        stage_done[i] <= (lat[i] == 1);
        rem[i]        <= (lat[i] > 1) ? lat[i] - 1 : 0;
      end else if (rem[i] == 1) begin
        stage_done[i] <= 1'b1;
        rem[i]        <= 0;
      end else if (rem[i] > 1) begin
        rem[i] <= rem[i] - 1;
      end
      if (stage_start[i]) starts[i] <= starts[i] + 1;
    end
    if (output_valid) vcount <= vcount + 1;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_valid(input int maxc, output int cyc, output bit ok);
    ok = 0; cyc = 0;
    while (cyc < maxc && !ok) begin
      tick(); cyc++;
      if (output_valid) ok = 1;
    end
  endtask

  task automatic apply_cfg(input logic [NS-1:0] mask, input logic [5:0] dly);
    int n = 0;
    enable_mask_in = mask; delay_amount_in = dly;
    tick();
    while ((busy || stage_reset) && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, output_valid, timeout_flag, stage_start} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {busy, output_valid, timeout_flag, stage_start});
    end
    checks++;
    if (stage_reset !== 1'b1) begin errors++; $display("FAIL reset_stage_reset: got %b want 1", stage_reset); end
    checks++;
    if ({overrun_count, delay_amount, stage_enable} !== 17'd0) begin
      errors++; $display("FAIL reset_cfg: got %h want 0", {overrun_count, delay_amount, stage_enable});
    end
    checks++;
    if ({modified_sample, stage_sample_in} !== 24'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {modified_sample, stage_sample_in});
    end
    reset = 1'b0;
    while (stage_reset && n < 10) begin n++; tick(); end
    checks++;
    if (n != 2) begin errors++; $display("FAIL reset_release_pulse: got %0d want 2", n); end
  endtask

  task automatic test_bypass();
    int first = -1, pulses = 0;
    int s0 [NS];
    for (int i = 0; i < NS; i++) s0[i] = starts[i];
    incoming_sample = 12'sh123; sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (output_valid) begin pulses++; if (first < 0) first = c; end
      tick();
    end
    checks++;
    if (first != 4) begin errors++; $display("FAIL bypass_latency: got %0d want 4", first); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL bypass_pulses: got %0d want 1", pulses); end
    checks++;
    if (modified_sample !== 12'sh123) begin errors++; $display("FAIL bypass_value: got %h want 123", modified_sample); end
    checks++;
    if ((starts[0] - s0[0]) + (starts[1] - s0[1]) + (starts[2] - s0[2]) != 0) begin
      errors++; $display("FAIL bypass_no_start: got %0d want 0", starts[0] + starts[1] + starts[2]);
    end
  endtask

  task automatic test_single_stage();
    int s0, s1, n = 0;
    bit ok = 0, seen = 0;
    logic signed [W-1:0] drv = '0;
    lat[0] = 2; dlt[0] = -12'sd5;
    apply_cfg(3'b001, 6'd0);
    checks++;
    if (stage_enable !== 3'b001) begin errors++; $display("FAIL single_cfg: got %b want 001", stage_enable); end
    s0 = starts[0]; s1 = starts[1] + starts[2];
    incoming_sample = 12'sd100; sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    while (!ok && n < 50) begin
      if (stage_start[0]) begin seen = 1; drv = stage_sample_in; end
      tick(); n++;
      if (output_valid) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL single_valid: got none want pulse within 50"); end
    checks++;
    if (!seen || drv !== 12'sd100) begin errors++; $display("FAIL single_drive: got %0d want 100", drv); end
    checks++;
    if (modified_sample !== 12'sd95) begin errors++; $display("FAIL single_value: got %0d want 95", modified_sample); end
    checks++;
    if (starts[0] - s0 != 1 || starts[1] + starts[2] != s1) begin
      errors++; $display("FAIL single_starts: got %0d want 1", starts[0] - s0);
    end
  endtask

  task automatic test_timeout();
    int cyc, s0, s1;
    bit ok;
    lat[0] = 2; dlt[0] = -12'sd5; lat[1] = 0;
    apply_cfg(3'b011, 6'd0);
    checks++;
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL timeout_pre: got %b want 0", timeout_flag); end
    s0 = starts[0]; s1 = starts[1];
    incoming_sample = 12'sd100; sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    wait_valid(1300, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_valid: got none want pulse within 1300"); end
    checks++;
    if (cyc <= 1024 || cyc >= 1040) begin errors++; $display("FAIL timeout_duration: got %0d want 1025..1039", cyc); end
    checks++;
    if (timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout_flag); end
    checks++;
    if (modified_sample !== 12'sd95) begin errors++; $display("FAIL timeout_value: got %0d want 95", modified_sample); end
    checks++;
    if (starts[0] - s0 != 1 || starts[1] - s1 != 1) begin
      errors++; $display("FAIL timeout_starts: got %0d/%0d want 1/1", starts[0] - s0, starts[1] - s1);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || timeout_flag !== 1'b1) begin
      errors++; $display("FAIL timeout_idle: got busy=%b flag=%b want 0/1", busy, timeout_flag);
    end
  endtask

  task automatic test_config_defer();
    int n = 0, hi = 0;
    bit ok = 0, bad = 0;
    lat[0] = 20; lat[1] = 3; dlt[1] = 12'sd10;
    incoming_sample = 12'sd7; sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    repeat (5) tick();
    delay_amount_in = 6'd8;
    while (!ok && n < 200) begin
      if (delay_amount !== 6'd0 || stage_reset !== 1'b0) bad = 1;
      tick(); n++;
      if (output_valid) ok = 1;
    end
    checks++;
    if (!ok || bad) begin errors++; $display("FAIL defer_midchain: got ok=%b bad=%b want 1/0", ok, bad); end
    checks++;
    if (modified_sample !== 12'sd12) begin errors++; $display("FAIL defer_value: got %0d want 12", modified_sample); end
    for (int c = 0; c < 6; c++) begin tick(); if (stage_reset) hi++; end
    checks++;
    if (hi != 2) begin errors++; $display("FAIL defer_pulse: got %0d want 2", hi); end
    checks++;
    if (delay_amount !== 6'd8) begin errors++; $display("FAIL defer_applied: got %0d want 8", delay_amount); end
  endtask

  task automatic test_overrun();
    int cyc;
    bit ok;
    lat[0] = 400;
    incoming_sample = 12'sd50; sample_ready = 1'b1; delay_amount_in = 6'd5;
    tick();
    sample_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || delay_amount !== 6'd8) begin
      errors++; $display("FAIL coincide_priority: got busy=%b delay=%0d want 1/8", busy, delay_amount);
    end
    tick(); tick();
    repeat (3) begin sample_ready = 1'b1; tick(); sample_ready = 1'b0; tick(); end
    checks++;
    if (overrun_count !== 8'd3) begin errors++; $display("FAIL overrun_three: got %0d want 3", overrun_count); end
    sample_ready = 1'b1;
    repeat (300) tick();
    sample_ready = 1'b0;
    checks++;
    if (overrun_count !== 8'd255) begin errors++; $display("FAIL overrun_saturate: got %0d want 255", overrun_count); end
    wait_valid(600, cyc, ok);
    checks++;
    if (!ok || modified_sample !== 12'sd55) begin
      errors++; $display("FAIL overrun_value: got %0d want 55", modified_sample);
    end
    apply_cfg(3'b011, 6'd5);
    checks++;
    if (delay_amount !== 6'd5) begin errors++; $display("FAIL coincide_later: got %0d want 5", delay_amount); end
  endtask

  task automatic test_reset_midchain();
    int v0, n = 0;
    lat[0] = 400;
    incoming_sample = 12'sd9; sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    repeat (50) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_precond: got busy=%b want 1", busy); end
    v0 = vcount;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, output_valid, timeout_flag, stage_start, overrun_count, delay_amount, stage_enable} !== 23'd0
        || {modified_sample, stage_sample_in} !== 24'd0 || stage_reset !== 1'b1) begin
      errors++; $display("FAIL abort_outputs: got busy=%b ovr=%0d dly=%0d rst=%b want 0/0/0/1",
                         busy, overrun_count, delay_amount, stage_reset);
    end
    delay_amount_in = 6'd0; enable_mask_in = 3'b000;
    repeat (3) tick();
    reset = 1'b0;
    while (stage_reset && n < 10) begin n++; tick(); end
    checks++;
    if (n != 2) begin errors++; $display("FAIL abort_release_pulse: got %0d want 2", n); end
    repeat (500) tick();
    checks++;
    if (vcount != v0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", vcount - v0);
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin lat[i] = 0; dlt[i] = '0; end
    test_reset();
    test_bypass();
    test_single_stage();
    test_timeout();
    test_config_defer();
    test_overrun();
    test_reset_midchain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
